// File: rtl/pixel_word_unpacker.sv
// Unpacks wide SDRAM pixel-FIFO words into a 24-bit RGB pixel stream through a two-word
// prefetch buffer (CUR/NXT), tracking frame position and a sticky underrun flag.
module pixel_word_unpacker #(
   parameter int DATA_WIDTH   = 256,
   parameter int READ_LATENCY = 1,
   parameter int H_ACTIVE     = 1920,
   parameter int V_ACTIVE     = 1080
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] pixfifo_word_i,
   output logic                  pixfifo_req_o,
   input  logic                  pix_ready_i,
   output logic                  pix_valid_o,
   output logic [23:0]           pix_o,
   output logic                  sof_o,
   output logic                  eol_o,
   output logic                  underrun_o
);

   localparam int PIX_PER_WORD = DATA_WIDTH / 32;
   localparam int IW           = $clog2(PIX_PER_WORD);
   localparam int HW           = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int VW           = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(PIX_PER_WORD - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE - 1);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   cur_q, cur_d;
   logic [DATA_WIDTH-1:0]   nxt_q, nxt_d;
   logic                    cur_full_q, cur_full_d;
   logic                    nxt_full_q, nxt_full_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [HW-1:0]           hcnt_q, hcnt_d;
   logic [VW-1:0]           vcnt_q, vcnt_d;
   logic [2:0]              outst_q, outst_d;
   logic                    underrun_q, underrun_d;
   logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
   logic [23:0]             pix_q, pix_d;
   logic                    sof_q, sof_d;
   logic                    eol_q, eol_d;

   logic                    req_s;
   logic                    arrival_s;
   logic                    consume_s;
   logic [1:0]              empty_cnt_s;

   function automatic logic [23:0] slot_pixel(input logic [DATA_WIDTH-1:0] word,
                                              input logic [IW-1:0]         idx);
      slot_pixel = word[{idx, 5'd0} +: 24];
   endfunction

   // Request issue, word capture, consume, frame counters and flush sequencing.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      cur_full_d = cur_full_q;
      nxt_full_d = nxt_full_q;
      idx_d      = idx_q;
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      underrun_d = underrun_q;
      consume_s  = 1'b0;

      empty_cnt_s = {1'b0, ~cur_full_q} + {1'b0, ~nxt_full_q};
      arrival_s   = rd_pipe_q[READ_LATENCY-1];
      // Only buffer space not already claimed by an in-flight word may be requested.
      req_s       = !rst_i && !flush_i && (state_q == ST_RUN) && enable_i
                    && ({1'b0, empty_cnt_s} > outst_q);
      outst_d     = outst_q + {2'b00, req_s} - {2'b00, arrival_s};

      rd_pipe_d[0] = req_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end

      if (flush_i) begin
         cur_full_d = 1'b0;
         nxt_full_d = 1'b0;
         idx_d      = '0;
         hcnt_d     = '0;
         vcnt_d     = '0;
         underrun_d = 1'b0;
         state_d    = (outst_d == 3'd0) ? ST_RUN : ST_FLUSH;
      end else begin
         case (state_q)
            ST_RUN: begin
               consume_s = pix_ready_i && cur_full_q;
               if (pix_ready_i && !cur_full_q) begin
                  underrun_d = 1'b1;
               end else begin
                  underrun_d = underrun_q;
               end
               if (consume_s) begin
                  if (hcnt_q == H_LAST) begin
                     hcnt_d = '0;
                     vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
                  if (idx_q == IDX_LAST) begin
                     idx_d      = '0;
                     cur_d      = nxt_q;
                     cur_full_d = nxt_full_q;
                     nxt_full_d = 1'b0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  idx_d = idx_q;
               end
               // Arrival lands after any promotion, so a word racing the last-slot consume
               // goes straight into CUR and the stream keeps flowing.
               if (arrival_s) begin
                  if (!cur_full_d) begin
                     cur_d      = pixfifo_word_i;
                     cur_full_d = 1'b1;
                  end else begin
                     nxt_d      = pixfifo_word_i;
                     nxt_full_d = 1'b1;
                  end
               end else begin
                  nxt_d = nxt_d;
               end
            end
            ST_FLUSH: begin
               state_d = (outst_d == 3'd0) ? ST_RUN : ST_FLUSH;
            end
            default: begin
               state_d    = ST_RUN;
               cur_full_d = 1'b0;
               nxt_full_d = 1'b0;
            end
         endcase
      end

      pix_d = cur_full_d ? slot_pixel(cur_d, idx_d) : 24'd0;
      sof_d = cur_full_d && (hcnt_d == '0) && (vcnt_d == '0);
      eol_d = cur_full_d && (hcnt_d == H_LAST);
   end

   // State, buffer and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         cur_q      <= '0;
         nxt_q      <= '0;
         cur_full_q <= 1'b0;
         nxt_full_q <= 1'b0;
         idx_q      <= '0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         outst_q    <= 3'd0;
         underrun_q <= 1'b0;
         rd_pipe_q  <= '0;
         pix_q      <= 24'd0;
         sof_q      <= 1'b0;
         eol_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         nxt_q      <= nxt_d;
         cur_full_q <= cur_full_d;
         nxt_full_q <= nxt_full_d;
         idx_q      <= idx_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         outst_q    <= outst_d;
         underrun_q <= underrun_d;
         rd_pipe_q  <= rd_pipe_d;
         pix_q      <= pix_d;
         sof_q      <= sof_d;
         eol_q      <= eol_d;
      end
   end

   assign pixfifo_req_o = req_s;
   assign pix_valid_o   = cur_full_q;
   assign pix_o         = pix_q;
   assign sof_o         = sof_q;
   assign eol_o         = eol_q;
   assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Bench for pixel_word_unpacker: FIFO model with 3-cycle read latency, table-driven vectors
// for fill/drain/underrun/flush/reset, and a modelled 64-pixel continuous stream.
module tb_pixel_word_unpacker;

   localparam int DW  = 256;
   localparam int RL  = 3;
   localparam int PPW = DW / 32;

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b1;
   logic          enable_i    = 1'b0;
   logic          flush_i     = 1'b0;
   logic          pix_ready_i = 1'b0;
   logic [DW-1:0] pixfifo_word_i = '0;
   logic          pixfifo_req_o;
   logic          pix_valid_o;
   logic [23:0]   pix_o;
   logic          sof_o;
   logic          eol_o;
   logic          underrun_o;

   pixel_word_unpacker #(
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL),
      .H_ACTIVE     (8),
      .V_ACTIVE     (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .enable_i       (enable_i),
      .flush_i        (flush_i),
      .pixfifo_word_i (pixfifo_word_i),
      .pixfifo_req_o  (pixfifo_req_o),
      .pix_ready_i    (pix_ready_i),
      .pix_valid_o    (pix_valid_o),
      .pix_o          (pix_o),
      .sof_o          (sof_o),
      .eol_o          (eol_o),
      .underrun_o     (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        en;
      logic        rdy;
      logic        fl;
      logic [28:0] exp;
   } vec_t;

   vec_t tab[$];
   int   passed = 0;
   int   total  = 0;
   int   pipe_w [0:RL];
   int   next_n = 1;

   function automatic logic [23:0] px(input int n, input int k);
      return {8'(n), 8'(k), 8'(n)};
   endfunction

   function automatic logic [DW-1:0] make_word(input int n);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < PPW; k++) w[32*k +: 32] = {8'h00, px(n, k)};
      return w;
   endfunction

   function automatic logic [28:0] ev(input logic rq, input logic v, input logic [23:0] p,
                                      input logic s, input logic e, input logic u);
      return {rq, v, p, s, e, u};
   endfunction

   function automatic vec_t mk(input logic rst, input logic en, input logic rdy,
                               input logic fl, input logic [28:0] e);
      vec_t r;
      r.rst = rst; r.en = en; r.rdy = rdy; r.fl = fl; r.exp = e;
      return r;
   endfunction

   function automatic logic [28:0] outs();
      return {pixfifo_req_o, pix_valid_o, pix_o, sof_o, eol_o, underrun_o};
   endfunction

   // FIFO read port: word number n (from 1) is presented RL cycles after its request.
   always @(negedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i <= RL; i++) pipe_w[i] = 0;
         next_n = 1;
      end else begin
         for (int i = RL; i > 0; i--) pipe_w[i] = pipe_w[i-1];
         if (pixfifo_req_o) begin
            pipe_w[0] = next_n;
            next_n    = next_n + 1;
         end else begin
            pipe_w[0] = 0;
         end
      end
      pixfifo_word_i = (pipe_w[RL] != 0) ? make_word(pipe_w[RL]) : {8{32'hEEEE_EEEE}};
   end

   task automatic check(input string name, input int idx, input logic [28:0] got,
                        input logic [28:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s[%0d]: got %h expected %h ({req,valid,pix,sof,eol,underrun})",
                    name, idx, got, exp);
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1; enable_i = 1'b0; pix_ready_i = 1'b0; flush_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic run_table(input string name);
      foreach (tab[i]) begin
         @(posedge clk_i); #1;
         rst_i = tab[i].rst; enable_i = tab[i].en; pix_ready_i = tab[i].rdy; flush_i = tab[i].fl;
         @(negedge clk_i);
         check(name, i, outs(), tab[i].exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic found;

      // Fill after reset, then drain two words with requests disabled into underrun.
      tab.delete();
      for (int c = 0; c < 4; c++)
         tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(c < 2, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      for (int c = 4; c < 8; c++)
         tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, px(1, 0), 1'b1, 1'b0, 1'b0)));
      for (int j = 0; j < 16; j++)
         tab.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0,
                          ev(1'b0, 1'b1, px(1 + j / 8, j % 8), j == 0, (j % 8) == 7, 1'b0)));
      for (int c = 24; c < 28; c++)
         tab.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, ev(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, c >= 25)));
      do_reset();
      run_table("fill_drain");

      // Continuous stream; a delayed request makes one arrival coincide with a last-slot consume.
      do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b0; enable_i = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk_i);
         if (pix_valid_o) found = 1'b1;
      end
      total++;
      if (found) passed++;
      else $display("FAIL first_fill: pix_valid_o still %b after 20 cycles, required 1", pix_valid_o);
      @(posedge clk_i); #1;
      for (int p = 0; p < 64; p++) begin
         @(posedge clk_i); #1;
         pix_ready_i = 1'b1;
         enable_i    = !(p >= 16 && p < 20);
         @(negedge clk_i);
         check("stream", p, {1'b0, pix_valid_o, pix_o, sof_o, eol_o, underrun_o},
               ev(1'b0, 1'b1, px(p / 8 + 1, p % 8), (p % 16) == 0, (p % 8) == 7, 1'b0));
      end

      // Underrun, flush at idx 3 with one word in flight, refill, then a reset pulse.
      tab.delete();
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1)));
      for (int c = 2; c < 4; c++)
         tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1)));
      for (int j = 0; j < 8; j++)
         tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b1, px(1, j), j == 0, j == 7, 1'b1)));
      tab.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, ev(1'b0, 1'b1, px(2, 0), 1'b0, 1'b0, 1'b1)));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b1, px(2, 1), 1'b0, 1'b0, 1'b1)));
      tab.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b1, px(2, 2), 1'b0, 1'b0, 1'b1)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b1, px(2, 3), 1'b0, 1'b0, 1'b1)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      for (int c = 19; c < 21; c++)
         tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, px(4, 0), 1'b1, 1'b0, 1'b0)));
      tab.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, px(4, 0), 1'b1, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      for (int c = 25; c < 27; c++)
         tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0)));
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, px(1, 0), 1'b1, 1'b0, 1'b0)));
      do_reset();
      run_table("flush_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
